fetch_stage: RTL

- Instruction fetch stage; sits directly upstream of the instruction decoder and feeds it one 32-bit instruction word plus its PC per handshake.
- Owns the PC register and issues word requests to instruction memory over a valid/ready request channel; captures responses in a small FIFO.
- Accepts branch/jump redirects from EX, which flush all fetched-but-unconsumed words.

---
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: PC + one-outstanding imem request, {pc,instr} FIFO to decode; accept N -> if_valid N+2; id_ready low stalls via credit.
// Optional FETCH_MISALIGN_EN: misaligned redirect halts fetch and emits one flagged NOP entry (if_misalign).
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        if_misalign
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2, S_HALT = 2'd3} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state, state_nx;
  logic [31:0]   pc, pc_nx, req_pc;
  entry_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          accept, pop, push, in_flight, credit, busy_after;
  entry_t        push_dat;
`ifdef FETCH_MISALIGN_EN
  logic          halt_drain, halt_drain_nx, halt_done, halt_done_nx, push_mis;
  logic          mis_mem [FIFO_DEPTH];
`endif

  assign accept = imem_req_valid && imem_req_ready;
  assign pop    = if_valid && id_ready && !redirect_valid;

  always_comb begin
    in_flight = (state == S_WAIT) || (state == S_DRAIN);
`ifdef FETCH_MISALIGN_EN
    if (state == S_HALT) in_flight = halt_drain;
`endif
    credit = (int'(count) + int'(in_flight)) < FIFO_DEPTH;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nx;
  end

  // busy_after: a request is still owed a response after this cycle
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    push       = 1'b0;
    push_dat   = '{pc: req_pc, instr: imem_rsp_data};
    busy_after = 1'b0;
`ifdef FETCH_MISALIGN_EN
    halt_drain_nx = halt_drain;
    halt_done_nx  = halt_done;
    push_mis      = 1'b0;
`endif
    unique case (state)
      S_REQ: begin
        if (accept) begin
          state_nx = S_WAIT;
          pc_nx    = pc + 32'd4;
        end
        busy_after = accept;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          push     = 1'b1;
          state_nx = S_REQ;
        end
        busy_after = !imem_rsp_valid;
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_nx = S_REQ;
        busy_after = !imem_rsp_valid;
      end
      default: begin
`ifdef FETCH_MISALIGN_EN
        busy_after = halt_drain && !imem_rsp_valid;
        if (halt_drain) begin
          if (imem_rsp_valid) halt_drain_nx = 1'b0;
        end else if (!halt_done) begin
          push         = 1'b1;
          push_dat     = '{pc: pc, instr: 32'h0000_0013};
          push_mis     = 1'b1;
          halt_done_nx = 1'b1;
        end
`else
        state_nx = S_REQ;
`endif
      end
    endcase
    // A response landing in the redirect cycle retires the old request, so DRAIN is only kept if one is still owed.
    if (redirect_valid) begin
      push     = 1'b0;
      pc_nx    = redirect_pc & 32'hFFFF_FFFC;
      state_nx = busy_after ? S_DRAIN : S_REQ;
`ifdef FETCH_MISALIGN_EN
      push_mis = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        pc_nx         = redirect_pc;
        state_nx      = S_HALT;
        halt_drain_nx = busy_after;
        halt_done_nx  = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    imem_req_valid = !rst && (state == S_REQ) && credit;
    imem_req_addr  = pc;
    if_valid       = !rst && (count != '0);
    if_instr       = '0;
    if_pc          = '0;
    if (if_valid) begin
      if_instr = fifo_mem[rd_ptr].instr;
      if_pc    = fifo_mem[rd_ptr].pc;
    end
`ifdef FETCH_MISALIGN_EN
    if_misalign = if_valid && mis_mem[rd_ptr];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
`ifdef FETCH_MISALIGN_EN
      halt_drain <= 1'b0;
      halt_done  <= 1'b0;
`endif
    end else begin
      pc <= pc_nx;
      if (accept) req_pc <= pc;
`ifdef FETCH_MISALIGN_EN
      halt_drain <= halt_drain_nx;
      halt_done  <= halt_done_nx;
`endif
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_dat;
`ifdef FETCH_MISALIGN_EN
      mis_mem[wr_ptr]  <= push_mis;
`endif
    end
  end

endmodule
